spi_adc_responder: RTL and testbench
====================================

// Module: spi_adc_responder
// PURPOSE
//  SPI slave (mode 0) emulating the 12-bit ADC that SPI_state_machine polls: on each CS-low
//  frame it shifts out the latest sample on MISO and captures the master's MOSI word.
//  Gives the SPI master/LED/display chain a loop-back target on-chip and in simulation.
//  Runs on the system clock; SCK/CS/MOSI are asynchronous, synchronised and edge-detected.
// PARAMETERS
//  DATA_W      12  sample width, sent MSB-first after the leading zeros
//  FRAME_BITS  16  SCK cycles per frame; leading zeros = FRAME_BITS-DATA_W (must be >= 0)
//  SYNC_STAGES 2   flip-flop stages on SCK, CS, MOSI (>= 2)
// PORTS
//  clk           in   1           system clock
//  reset         in   1           synchronous, active-high
//  SCK           in   1           SPI clock from master, idle low
//  CS            in   1           chip select from master, active low
//  MOSI          in   1           master-to-slave data
//  MISO          out  1           slave-to-master data
//  miso_oe       out  1           1 while a frame is active (for an external tri-state)
//  i_DATA        in   DATA_W      sample to serve
//  i_DATA_VALID  in   1           1-cycle strobe loading i_DATA into the hold register
//  o_RX_DATA     out  FRAME_BITS  last complete MOSI word, MSB first
//  o_RX_VALID    out  1           1-cycle pulse when o_RX_DATA is updated
//  o_BUSY        out  1           1 in SHIFT state
//  o_ABORT       out  1           1-cycle pulse when CS rises before FRAME_BITS rising SCK edges
// BEHAVIOUR
//  Reset: MISO=0, miso_oe=0, o_RX_DATA=0, o_RX_VALID=0, o_BUSY=0, o_ABORT=0, hold=0,
//   bit count=0, state=ARM. Reset overrides every other event in the same cycle.
//  Sync: SYNC_STAGES flops per input plus one history flop; rise/fall detected on synced values.
//   Requirement on master: SCK high, SCK low and CS high each last >= SYNC_STAGES+1 clk.
//  Hold register: loads i_DATA whenever i_DATA_VALID=1, in any state.
//  States:
//   ARM   - after reset; waits for synced CS=1, then -> IDLE (a frame already running at
//           reset release is ignored entirely, no MISO activity, no pulses).
//   IDLE  - MISO=0, miso_oe=0. CS fall -> SHIFT: tx shift reg <= {zeros, hold}; if
//           i_DATA_VALID in that same cycle, i_DATA is used instead (bypass). count<=0.
//   SHIFT - miso_oe=1, o_BUSY=1, MISO=tx[FRAME_BITS-1].
//           SCK rise: rx <= {rx[FRAME_BITS-2:0], MOSI_sync}; count<=count+1 (saturating at FRAME_BITS).
//           SCK fall: tx <= tx<<1 (zero fill), so MISO changes on falling edges only.
//           Edges after count==FRAME_BITS: rx frozen, MISO=0.
//           CS rise: count==FRAME_BITS -> o_RX_DATA<=rx, o_RX_VALID=1; else o_ABORT=1,
//           o_RX_DATA unchanged. Either way -> IDLE next cycle.
//           CS rise has priority over an SCK edge detected in the same cycle (edge ignored).
//  Latency: MISO updates SYNC_STAGES+1 clk after SCK fall at the pin; o_RX_VALID/o_ABORT
//   asserted SYNC_STAGES+1 clk after CS rise at the pin.
//  Arithmetic: count is clog2(FRAME_BITS+1) bits; no wrap.
// TESTING
//  hold=0xABC, frame with MOSI=0x1234 -> MISO 0000_1010_1011_1100, o_RX_DATA=0x1234, one RX_VALID.
//  CS rises after 7 SCK rises -> o_ABORT pulse once, o_RX_VALID=0, o_RX_DATA keeps 0x1234.
//  reset pulse while CS low mid-frame -> MISO=0, miso_oe=0 until CS high then low; next frame correct.
//  i_DATA_VALID with i_DATA=0x5A5 on the cycle CS-fall is detected -> frame sends 0x5A5, not old hold.
//  20 SCK cycles in one frame -> bits 17..20 MISO=0, o_RX_DATA = first 16 MOSI bits, RX_VALID.
//  two back-to-back frames, CS high for exactly SYNC_STAGES+1 clk -> both complete, two RX_VALIDs.

Source files
------------

// File: rtl/spi_adc_responder.sv
// spi_adc_responder
// SPI mode-0 slave that stands in for the 12-bit ADC polled by the SPI master.
// Each CS-low frame shifts the held sample out on MISO (MSB first, after the
// leading zeros) and captures the master's MOSI word. SCK, CS and MOSI are
// asynchronous to clk, so they are synchronised and edge-detected here.
module spi_adc_responder #(
  parameter int DATA_W      = 12,
  parameter int FRAME_BITS  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  SCK,
  input  logic                  CS,
  input  logic                  MOSI,
  output logic                  MISO,
  output logic                  miso_oe,
  input  logic [DATA_W-1:0]     i_DATA,
  input  logic                  i_DATA_VALID,
  output logic [FRAME_BITS-1:0] o_RX_DATA,
  output logic                  o_RX_VALID,
  output logic                  o_BUSY,
  output logic                  o_ABORT
);

  localparam int CNT_W = $clog2(FRAME_BITS + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);

  typedef enum logic [1:0] {
    ST_ARM   = 2'd0,
    ST_IDLE  = 2'd1,
    ST_SHIFT = 2'd2
  } state_t;

  state_t                  state_r, state_nxt_s;
  logic [SYNC_STAGES-1:0]  sck_sync_r, cs_sync_r, mosi_sync_r;
  logic                    sck_hist_r, cs_hist_r;
  logic                    sck_s, cs_s, mosi_s;
  logic                    sck_rise_s, sck_fall_s, cs_rise_s, cs_fall_s;
  logic [DATA_W-1:0]       hold_r;
  logic [FRAME_BITS-1:0]   tx_r, tx_nxt_s;
  logic [FRAME_BITS-1:0]   rx_r, rx_nxt_s;
  logic [FRAME_BITS-1:0]   rx_data_nxt_s;
  logic [CNT_W-1:0]        cnt_r, cnt_nxt_s;
  logic                    miso_nxt_s, rx_valid_nxt_s, abort_nxt_s;

  assign sck_s      = sck_sync_r[SYNC_STAGES-1];
  assign cs_s       = cs_sync_r[SYNC_STAGES-1];
  assign mosi_s     = mosi_sync_r[SYNC_STAGES-1];
  assign sck_rise_s = sck_s & ~sck_hist_r;
  assign sck_fall_s = ~sck_s & sck_hist_r;
  assign cs_rise_s  = cs_s & ~cs_hist_r;
  assign cs_fall_s  = ~cs_s & cs_hist_r;

  // Synchroniser chains plus one history flop for edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      sck_sync_r  <= '0;
      cs_sync_r   <= '0;
      mosi_sync_r <= '0;
      sck_hist_r  <= 1'b0;
      cs_hist_r   <= 1'b0;
    end else begin
      sck_sync_r  <= {sck_sync_r[SYNC_STAGES-2:0], SCK};
      cs_sync_r   <= {cs_sync_r[SYNC_STAGES-2:0], CS};
      mosi_sync_r <= {mosi_sync_r[SYNC_STAGES-2:0], MOSI};
      sck_hist_r  <= sck_s;
      cs_hist_r   <= cs_s;
    end
  end

  // Sample hold register, loaded on every valid strobe regardless of state.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_r <= '0;
    end else if (i_DATA_VALID) begin
      hold_r <= i_DATA;
    end else begin
      hold_r <= hold_r;
    end
  end

  // Next-state and datapath decode; CS rise outranks any SCK edge in SHIFT.
  always_comb begin
    state_nxt_s    = state_r;
    tx_nxt_s       = tx_r;
    rx_nxt_s       = rx_r;
    cnt_nxt_s      = cnt_r;
    rx_data_nxt_s  = o_RX_DATA;
    rx_valid_nxt_s = 1'b0;
    abort_nxt_s    = 1'b0;
    case (state_r)
      ST_ARM: begin
        if (cs_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_ARM;
        end
      end
      ST_IDLE: begin
        if (cs_fall_s) begin
          state_nxt_s = ST_SHIFT;
          tx_nxt_s    = FRAME_BITS'(i_DATA_VALID ? i_DATA : hold_r);
          cnt_nxt_s   = '0;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (cs_rise_s) begin
          state_nxt_s = ST_IDLE;
          if (cnt_r == CNT_FULL) begin
            rx_data_nxt_s  = rx_r;
            rx_valid_nxt_s = 1'b1;
          end else begin
            abort_nxt_s = 1'b1;
          end
        end else if (sck_rise_s) begin
          if (cnt_r != CNT_FULL) begin
            rx_nxt_s  = {rx_r[FRAME_BITS-2:0], mosi_s};
            cnt_nxt_s = cnt_r + CNT_W'(1);
          end else begin
            cnt_nxt_s = cnt_r;
          end
        end else if (sck_fall_s) begin
          tx_nxt_s = {tx_r[FRAME_BITS-2:0], 1'b0};
        end else begin
          state_nxt_s = ST_SHIFT;
        end
      end
      default: begin
        state_nxt_s = ST_ARM;
      end
    endcase
    if (state_nxt_s == ST_SHIFT) begin
      miso_nxt_s = tx_nxt_s[FRAME_BITS-1];
    end else begin
      miso_nxt_s = 1'b0;
    end
  end

  // State, shift registers and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= ST_ARM;
      tx_r       <= '0;
      rx_r       <= '0;
      cnt_r      <= '0;
      MISO       <= 1'b0;
      miso_oe    <= 1'b0;
      o_BUSY     <= 1'b0;
      o_RX_DATA  <= '0;
      o_RX_VALID <= 1'b0;
      o_ABORT    <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      tx_r       <= tx_nxt_s;
      rx_r       <= rx_nxt_s;
      cnt_r      <= cnt_nxt_s;
      MISO       <= miso_nxt_s;
      miso_oe    <= (state_nxt_s == ST_SHIFT);
      o_BUSY     <= (state_nxt_s == ST_SHIFT);
      o_RX_DATA  <= rx_data_nxt_s;
      o_RX_VALID <= rx_valid_nxt_s;
      o_ABORT    <= abort_nxt_s;
    end
  end

endmodule

// File: tb/tb_spi_adc_responder.sv
// Bench for spi_adc_responder: drives SPI mode-0 frames, queues expected MISO
// bits and RX words up front, and compares them as the DUT produces them.
module tb_spi_adc_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        SCK;
  logic        CS;
  logic        MOSI;
  logic        MISO;
  logic        miso_oe;
  logic [11:0] i_DATA;
  logic        i_DATA_VALID;
  logic [15:0] o_RX_DATA;
  logic        o_RX_VALID;
  logic        o_BUSY;
  logic        o_ABORT;

  int checks   = 0;
  int failures = 0;
  int rx_valid_cnt = 0;
  int abort_cnt    = 0;

  bit          exp_miso_q[$];
  logic [15:0] exp_rx_q[$];
  logic [15:0] got_rx_q[$];

  spi_adc_responder #(.DATA_W(12), .FRAME_BITS(16), .SYNC_STAGES(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .SCK          (SCK),
    .CS           (CS),
    .MOSI         (MOSI),
    .MISO         (MISO),
    .miso_oe      (miso_oe),
    .i_DATA       (i_DATA),
    .i_DATA_VALID (i_DATA_VALID),
    .o_RX_DATA    (o_RX_DATA),
    .o_RX_VALID   (o_RX_VALID),
    .o_BUSY       (o_BUSY),
    .o_ABORT      (o_ABORT)
  );

  always #5 clk = ~clk;

  // Output monitor: counts pulse cycles and records every delivered RX word.
  always @(negedge clk) begin
    if (o_RX_VALID === 1'b1) begin
      rx_valid_cnt++;
      got_rx_q.push_back(o_RX_DATA);
    end
    if (o_ABORT === 1'b1) abort_cnt++;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load_hold(input logic [11:0] d);
    i_DATA = d;
    i_DATA_VALID = 1'b1;
    wait_clk(1);
    i_DATA_VALID = 1'b0;
    wait_clk(1);
  endtask

  // Queue the MISO bits a frame of n SCK cycles should carry for sample d.
  task automatic push_frame_bits(input logic [11:0] d, input int n);
    logic [15:0] word;
    word = {4'b0000, d};
    for (int i = 0; i < n; i++) begin
      if (i < 16) exp_miso_q.push_back(word[15 - i]);
      else        exp_miso_q.push_back(1'b0);
    end
  endtask

  // One CS-low frame; MISO is compared against the queue just before each SCK rise.
  task automatic spi_frame(input logic [31:0] mosi_word, input int n_bits,
                           input logic bypass, input logic [11:0] bypass_data);
    bit exp_bit;
    CS = 1'b0;
    wait_clk(2);
    if (bypass) begin
      i_DATA = bypass_data;
      i_DATA_VALID = 1'b1;
    end
    wait_clk(1);
    i_DATA_VALID = 1'b0;
    wait_clk(3);
    for (int i = 0; i < n_bits; i++) begin
      MOSI = mosi_word[n_bits - 1 - i];
      wait_clk(5);
      if (i == 0) begin
        checks++;
        if (miso_oe !== 1'b1 || o_BUSY !== 1'b1) begin
          failures++;
          $display("FAIL frame_active: miso_oe=%b o_BUSY=%b, required 1 1", miso_oe, o_BUSY);
        end
      end
      exp_bit = (exp_miso_q.size() > 0) ? exp_miso_q.pop_front() : 1'b0;
      checks++;
      if (MISO !== exp_bit) begin
        failures++;
        $display("FAIL miso_bit%0d: got %b, required %b", i, MISO, exp_bit);
      end
      SCK = 1'b1;
      wait_clk(5);
      SCK = 1'b0;
    end
    wait_clk(5);
    CS = 1'b1;
  endtask

  task automatic test_reset;
    reset = 1'b1; SCK = 1'b0; CS = 1'b1; MOSI = 1'b0;
    i_DATA = 12'h000; i_DATA_VALID = 1'b0;
    wait_clk(3);
    checks++; if (MISO !== 1'b0) begin failures++; $display("FAIL reset_miso: got %b, required 0", MISO); end
    checks++; if (miso_oe !== 1'b0) begin failures++; $display("FAIL reset_oe: got %b, required 0", miso_oe); end
    checks++; if (o_RX_DATA !== 16'h0000) begin failures++; $display("FAIL reset_rx_data: got %h, required 0000", o_RX_DATA); end
    checks++; if (o_RX_VALID !== 1'b0) begin failures++; $display("FAIL reset_rx_valid: got %b, required 0", o_RX_VALID); end
    checks++; if (o_BUSY !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b, required 0", o_BUSY); end
    checks++; if (o_ABORT !== 1'b0) begin failures++; $display("FAIL reset_abort: got %b, required 0", o_ABORT); end
    reset = 1'b0;
    wait_clk(6);
  endtask

  // Pops one queued RX expectation and checks it against the delivered word.
  task automatic test_normal;
    int v0;
    logic [15:0] exp_w;
    logic [15:0] got_w;
    v0 = rx_valid_cnt;
    load_hold(12'hABC);
    push_frame_bits(12'hABC, 16);
    exp_rx_q.push_back(16'h1234);
    spi_frame(32'h0000_1234, 16, 1'b0, 12'h000);
    wait_clk(8);
    checks++;
    if (rx_valid_cnt - v0 !== 1) begin failures++; $display("FAIL normal_valid_count: got %0d, required 1", rx_valid_cnt - v0); end
    exp_w = exp_rx_q.pop_front();
    got_w = (got_rx_q.size() > 0) ? got_rx_q.pop_front() : 16'hxxxx;
    checks++;
    if (got_w !== exp_w) begin failures++; $display("FAIL normal_rx_data: got %h, required %h", got_w, exp_w); end
    checks++;
    if (miso_oe !== 1'b0 || o_BUSY !== 1'b0) begin failures++; $display("FAIL normal_idle: miso_oe=%b busy=%b, required 0 0", miso_oe, o_BUSY); end
  endtask

  task automatic test_abort;
    int v0, a0;
    v0 = rx_valid_cnt; a0 = abort_cnt;
    push_frame_bits(12'hABC, 7);
    spi_frame(32'h0000_0055, 7, 1'b0, 12'h000);
    wait_clk(8);
    checks++; if (abort_cnt - a0 !== 1) begin failures++; $display("FAIL abort_pulse: got %0d cycles, required 1", abort_cnt - a0); end
    checks++; if (rx_valid_cnt - v0 !== 0) begin failures++; $display("FAIL abort_no_valid: got %0d, required 0", rx_valid_cnt - v0); end
    checks++; if (o_RX_DATA !== 16'h1234) begin failures++; $display("FAIL abort_rx_kept: got %h, required 1234", o_RX_DATA); end
  endtask

  task automatic test_reset_mid_frame;
    int v0, a0;
    logic [15:0] exp_w;
    logic [15:0] got_w;
    v0 = rx_valid_cnt; a0 = abort_cnt;
    CS = 1'b0;
    wait_clk(6);
    for (int i = 0; i < 3; i++) begin
      SCK = 1'b1; wait_clk(5); SCK = 1'b0; wait_clk(5);
    end
    reset = 1'b1;
    wait_clk(2);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      SCK = 1'b1; wait_clk(5);
      checks++;
      if (MISO !== 1'b0 || miso_oe !== 1'b0) begin failures++; $display("FAIL midreset_quiet_hi%0d: MISO=%b oe=%b, required 0 0", i, MISO, miso_oe); end
      SCK = 1'b0; wait_clk(5);
      checks++;
      if (MISO !== 1'b0 || o_BUSY !== 1'b0) begin failures++; $display("FAIL midreset_quiet_lo%0d: MISO=%b busy=%b, required 0 0", i, MISO, o_BUSY); end
    end
    CS = 1'b1;
    wait_clk(8);
    checks++; if (rx_valid_cnt - v0 !== 0 || abort_cnt - a0 !== 0) begin failures++; $display("FAIL midreset_pulses: valid=%0d abort=%0d, required 0 0", rx_valid_cnt - v0, abort_cnt - a0); end
    checks++; if (o_RX_DATA !== 16'h0000) begin failures++; $display("FAIL midreset_rx_cleared: got %h, required 0000", o_RX_DATA); end
    load_hold(12'h3C7);
    push_frame_bits(12'h3C7, 16);
    exp_rx_q.push_back(16'hBEEF);
    spi_frame(32'h0000_BEEF, 16, 1'b0, 12'h000);
    wait_clk(8);
    exp_w = exp_rx_q.pop_front();
    got_w = (got_rx_q.size() > 0) ? got_rx_q.pop_front() : 16'hxxxx;
    checks++;
    if (got_w !== exp_w) begin failures++; $display("FAIL midreset_next_frame: got %h, required %h", got_w, exp_w); end
  endtask

  task automatic test_bypass;
    logic [15:0] exp_w;
    logic [15:0] got_w;
    push_frame_bits(12'h5A5, 16);
    exp_rx_q.push_back(16'h0F0F);
    spi_frame(32'h0000_0F0F, 16, 1'b1, 12'h5A5);
    wait_clk(8);
    exp_w = exp_rx_q.pop_front();
    got_w = (got_rx_q.size() > 0) ? got_rx_q.pop_front() : 16'hxxxx;
    checks++;
    if (got_w !== exp_w) begin failures++; $display("FAIL bypass_rx: got %h, required %h", got_w, exp_w); end
  endtask

  task automatic test_long_frame;
    int v0;
    logic [15:0] exp_w;
    logic [15:0] got_w;
    v0 = rx_valid_cnt;
    push_frame_bits(12'h5A5, 20);
    exp_rx_q.push_back(16'hC3A5);
    spi_frame({12'h000, 16'hC3A5, 4'hF}, 20, 1'b0, 12'h000);
    wait_clk(8);
    checks++; if (rx_valid_cnt - v0 !== 1) begin failures++; $display("FAIL long_valid_count: got %0d, required 1", rx_valid_cnt - v0); end
    exp_w = exp_rx_q.pop_front();
    got_w = (got_rx_q.size() > 0) ? got_rx_q.pop_front() : 16'hxxxx;
    checks++;
    if (got_w !== exp_w) begin failures++; $display("FAIL long_rx_data: got %h, required %h", got_w, exp_w); end
  endtask

  task automatic test_back_to_back;
    int v0;
    logic [15:0] exp_w;
    logic [15:0] got_w;
    v0 = rx_valid_cnt;
    load_hold(12'h0F0);
    push_frame_bits(12'h0F0, 16);
    exp_rx_q.push_back(16'hA55A);
    push_frame_bits(12'h0F0, 16);
    exp_rx_q.push_back(16'h0FF0);
    spi_frame(32'h0000_A55A, 16, 1'b0, 12'h000);
    wait_clk(3);
    spi_frame(32'h0000_0FF0, 16, 1'b0, 12'h000);
    wait_clk(8);
    checks++; if (rx_valid_cnt - v0 !== 2) begin failures++; $display("FAIL b2b_valid_count: got %0d, required 2", rx_valid_cnt - v0); end
    for (int k = 0; k < 2; k++) begin
      exp_w = exp_rx_q.pop_front();
      got_w = (got_rx_q.size() > 0) ? got_rx_q.pop_front() : 16'hxxxx;
      checks++;
      if (got_w !== exp_w) begin failures++; $display("FAIL b2b_rx%0d: got %h, required %h", k, got_w, exp_w); end
    end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_abort();
    test_reset_mid_frame();
    test_bypass();
    test_long_frame();
    test_back_to_back();
    checks++;
    if (exp_miso_q.size() != 0 || got_rx_q.size() != 0) begin
      failures++;
      $display("FAIL queues_drained: miso_left=%0d rx_left=%0d, required 0 0", exp_miso_q.size(), got_rx_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
